ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised EX/MEM pipeline stage that replaces the fixed 24-bit execute-to-memory connection register. It registers the execute-stage result and control bits and performs the data-memory access with configurable latency. It presents a single result word, `memory_stage_out`, to writeback, selecting load data or the ALU result. A valid/ready handshake on both sides and a flush input let the stage stall and be squashed by the hazard unit.

## Interface
- `DATA_W`, 24: width of ALU result, store data and memory word.
- `ADDR_W`, 10: word-address bits taken from `alu_result[ADDR_W-1:0]`; memory depth is 2**ADDR_W.
- `REG_W`, 4: destination register index width.
- `MEM_LATENCY`, 1: read latency in clock edges; legal range 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash the held instruction and block capture this cycle.
- `in_valid`  in  1  execute stage presents an instruction.
- `in_ready`  out  1  stage can accept this cycle (combinational).
- `writeback_enable`  in  1  instruction writes the register file.
- `mem_read_enable`  in  1  load.
- `mem_write_enable`  in  1  store.
- `alu_result`  in  DATA_W  ALU result / memory byte-free word address.
- `write_data`  in  DATA_W  store data.
- `rd_addr`  in  REG_W  destination register.
- `out_valid`  out  1  result presented to writeback.
- `out_ready`  in  1  writeback accepts.
- `writeback_enable_out`  out  1  registered copy.
- `mem_read_enable_out`  out  1  registered copy.
- `rd_addr_out`  out  REG_W  registered copy.
- `memory_stage_out`  out  DATA_W  load data if load, else ALU result.
- `busy`  out  1  stage holds an instruction (state != IDLE).

## Operation
- FSM states: IDLE (empty), ACCESS (load waiting on memory), DONE (result held, `out_valid`=1).
- `in_ready` = !flush && (state==IDLE || (state==DONE && out_ready)).
- Accept occurs when `in_valid && in_ready`. The control bits, `rd_addr` and `alu_result` are captured.
- Accept with `mem_write_enable`=1: memory[alu_result[ADDR_W-1:0]] <= write_data on the accept edge. This is the only write point.
- Accept, non-load: next state DONE, `memory_stage_out` = captured `alu_result`.
- Accept, load, `MEM_LATENCY`=1: next state DONE, `memory_stage_out` = read data.
- Accept, load, `MEM_LATENCY`>1: next state ACCESS. A latency counter is loaded with `MEM_LATENCY-1` and decrements each cycle. At zero, the next state is DONE with load data.
- Load and store asserted together: write-first, so the load returns `write_data`.
- DONE with `out_ready`=1 and no new accept: next state IDLE, `out_valid` drops.
- DONE with `out_ready`=1 and an accept in the same cycle: back-to-back, with no bubble.
- `flush`, any state: next state IDLE, `out_valid`=0, counter cleared, no capture, no write that cycle. Stores already committed are not undone.
- `rst` has priority over `flush`. Next cycle: state IDLE and all outputs 0.
- Memory contents are not reset.
- Address bits above `ADDR_W` are ignored, so the address wraps modulo 2**ADDR_W.

## Timing
- Reset values: `out_valid`, `busy`, `writeback_enable_out`, `mem_read_enable_out` = 0. `rd_addr_out` and `memory_stage_out` = 0.
- Non-load latency: accept on edge N, `out_valid` from edge N.
- Load latency: `out_valid` from edge N+MEM_LATENCY-1 after the accept edge N, i.e. MEM_LATENCY edges counting the accept edge.
- Throughput is 1 instruction per cycle for non-loads. For loads with `MEM_LATENCY`=L, throughput is 1 per L cycles, because ACCESS blocks `in_ready`.
- Outputs are registered and stable while `out_valid && !out_ready`.

## Structure
- Package `ex_mem_pkg`:
  - state enum {IDLE, ACCESS, DONE};
  - `MEM_LATENCY_MAX`=4 constant;
  - packed struct `ex_mem_ctrl_t` {writeback_enable, mem_read_enable, rd_addr} for the pipelined control.
- Sub-module `data_memory_sync`: single-port synchronous RAM with write-first behaviour and a read pipeline of `MEM_LATENCY` registers. The stage FSM and counter live in `ex_mem_stage`.
- Elaboration-time check: `MEM_LATENCY` within 1..4.

## Test plan
- Reset then idle:
  - Hold `rst`=1 for 2 cycles with random inputs; all outputs are 0 and `in_ready`=0 during reset.
  - Release reset; `in_ready`=1.
- ALU pass-through:
  - Apply `writeback_enable`=1, `alu_result`=1, then 2, on consecutive cycles with `out_ready`=1.
  - `memory_stage_out` = 1, then 2, on successive edges; `out_valid` stays continuously 1.
- Store then load:
  - Store 24'hABCDEF to address 5, then load from `alu_result`=24'h400005 (wrap, `ADDR_W`=10).
  - `memory_stage_out`=24'hABCDEF; `mem_read_enable_out`=1.
- Latency and stall:
  - Use `MEM_LATENCY`=3, load from address 7 holding 24'h000123, with `out_ready`=0 for 4 cycles.
  - `in_ready`=0 for 3 cycles. `out_valid` rises 3 edges after accept and holds 24'h000123 stably until `out_ready`.
- Flush mid-access:
  - Use `MEM_LATENCY`=3, start a load, assert `flush` on the next cycle.
  - `out_valid` is never raised for that load; state returns to IDLE; the next instruction completes normally.
- Flush versus store:
  - Assert `flush` and a store to address 9 in the same cycle; memory[9] is unchanged.
  - Repeat the store without `flush`; memory[9] is updated.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX/MEM pipeline stage.
//   state_t        - stage FSM states (IDLE, ACCESS, DONE)
//   ex_mem_ctrl_t  - control bits carried from execute to writeback
//   MEM_LATENCY_MAX, CTRL_RD_W - elaboration limits
package ex_mem_pkg;

    localparam int unsigned MEM_LATENCY_MAX = 4;
    // rd_addr field is sized for the widest supported register index;
    // the stage zero-extends REG_W into it.
    localparam int unsigned CTRL_RD_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef struct packed {
        logic                 writeback_enable;
        logic                 mem_read_enable;
        logic [CTRL_RD_W-1:0] rd_addr;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_data_memory.sv
// data_memory_sync: single-port synchronous data RAM, write-first, followed
// by a read pipeline of MEM_LATENCY registers.
//   clk        - clock, rising edge
//   we, re     - write / read request (one-cycle pulses)
//   addr       - word address
//   wdata      - store data
//   shift      - advance the read pipeline by one register
//   rdata      - last pipeline register (load data)
// Contents and pipeline registers are deliberately not reset.
module data_memory_sync #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              shift,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q  [2**ADDR_W];
    logic [DATA_W-1:0] pipe_q [MEM_LATENCY];
    logic [DATA_W-1:0] pipe_d [MEM_LATENCY];
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Write-first: a simultaneous write forwards its data to the read port.
    assign rd_word = we ? wdata : mem_q[addr];

    // Stage 0 loads only on a read request; later stages advance on shift,
    // so the last register holds its value while the result is stalled.
    always_comb begin
        pipe_d = pipe_q;
        if (re) begin
            pipe_d[0] = rd_word;
        end
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            if (shift) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
    end

    assign rdata = pipe_q[MEM_LATENCY-1];

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with data-memory access.
// Inputs from execute (in_valid/in_ready handshake): writeback_enable,
// mem_read_enable, mem_write_enable, alu_result (word address in the low
// ADDR_W bits), write_data, rd_addr. flush squashes the held instruction.
// Outputs to writeback (out_valid/out_ready handshake): registered control
// copies, rd_addr_out and memory_stage_out (load data or ALU result).
// busy is high whenever the stage holds an instruction.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              writeback_enable,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_W-1:0]  rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              writeback_enable_out,
    output logic              mem_read_enable_out,
    output logic [REG_W-1:0]  rd_addr_out,
    output logic [DATA_W-1:0] memory_stage_out,
    output logic              busy
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
        $error("ex_mem_stage: MEM_LATENCY must be within 1..%0d", MEM_LATENCY_MAX);
    end
    if (REG_W > CTRL_RD_W) begin : g_bad_reg_w
        $error("ex_mem_stage: REG_W must not exceed %0d", CTRL_RD_W);
    end

    localparam int unsigned CNT_W = 3;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ex_mem_ctrl_t      ctrl_q, ctrl_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              accept;
    logic              ctrl_unused;

    assign in_ready = !rst && !flush &&
                      (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    data_memory_sync #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_data_memory (
        .clk   (clk),
        .we    (accept && mem_write_enable),
        .re    (accept && mem_read_enable),
        .addr  (alu_result[ADDR_W-1:0]),
        .wdata (write_data),
        .shift (state_q == ACCESS),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:   ;
                ACCESS: begin
                    // Move to DONE on the edge where the count reaches zero,
                    // which lines up with the last read-pipeline register.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = DONE;
                    end
                end
                DONE:   if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // accept is already gated by !flush, so it may override the above.
        if (accept) begin
            ctrl_d.writeback_enable = writeback_enable;
            ctrl_d.mem_read_enable  = mem_read_enable;
            ctrl_d.rd_addr          = CTRL_RD_W'(rd_addr);
            alu_d                   = alu_result;
            if (mem_read_enable && MEM_LATENCY > 1) begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
            end else begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
        end
    end

    assign out_valid            = (state_q == DONE);
    assign busy                 = (state_q != IDLE);
    assign writeback_enable_out = ctrl_q.writeback_enable;
    assign mem_read_enable_out  = ctrl_q.mem_read_enable;
    assign rd_addr_out          = ctrl_q.rd_addr[REG_W-1:0];
    assign memory_stage_out     = ctrl_q.mem_read_enable ? mem_rdata : alu_q;
    // Upper rd_addr bits beyond REG_W are always zero.
    assign ctrl_unused          = ^ctrl_q.rd_addr;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned LAT    = 3;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              writeback_enable;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  rd_addr;
    logic              out_valid;
    logic              out_ready;
    logic              writeback_enable_out;
    logic              mem_read_enable_out;
    logic [REG_W-1:0]  rd_addr_out;
    logic [DATA_W-1:0] memory_stage_out;
    logic              busy;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    ex_mem_stage #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .REG_W       (REG_W),
        .MEM_LATENCY (LAT)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .writeback_enable     (writeback_enable),
        .mem_read_enable      (mem_read_enable),
        .mem_write_enable     (mem_write_enable),
        .alu_result           (alu_result),
        .write_data           (write_data),
        .rd_addr              (rd_addr),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .writeback_enable_out (writeback_enable_out),
        .mem_read_enable_out  (mem_read_enable_out),
        .rd_addr_out          (rd_addr_out),
        .memory_stage_out     (memory_stage_out),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd,
                         input logic [REG_W-1:0] rd);
        in_valid         = v;
        writeback_enable = wb;
        mem_read_enable  = mr;
        mem_write_enable = mw;
        alu_result       = alu;
        write_data       = wd;
        rd_addr          = rd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic randomize_in();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              DATA_W'($urandom), DATA_W'($urandom), REG_W'($urandom));
        flush     = 1'($urandom);
        out_ready = 1'($urandom);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_wb_out"},    32'(writeback_enable_out), 32'd0);
        chk({tag, "_mr_out"},    32'(mem_read_enable_out), 32'd0);
        chk({tag, "_rd_out"},    32'(rd_addr_out), 32'd0);
        chk({tag, "_data"},      32'(memory_stage_out), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready), 32'd0);
    endtask

    // Issues a load from addr and waits out LAT edges; result checked by caller.
    task automatic load_and_wait(input logic [DATA_W-1:0] addr, input logic [REG_W-1:0] rd);
        drive(1'b1, 1'b1, 1'b1, 1'b0, addr, '0, rd);
        step();
        idle_in();
        for (int i = 1; i < int'(LAT); i++) step();
    endtask

    initial begin
        rst   = 1'b1;
        randomize_in();

        // Reset with random inputs
        step();
        randomize_in();
        #1;
        chk_reset("rst1");
        step();
        randomize_in();
        #1;
        chk_reset("rst2");

        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle_in();
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // ALU pass-through, back-to-back
        drive(1'b1, 1'b1, 1'b0, 1'b0, 24'd1, '0, 4'd3);
        step();
        chk("pt1_valid", 32'(out_valid), 32'd1);
        chk("pt1_data", 32'(memory_stage_out), 32'd1);
        chk("pt1_wb", 32'(writeback_enable_out), 32'd1);
        chk("pt1_rd", 32'(rd_addr_out), 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 24'd2, '0, 4'd4);
        #1;
        chk("pt_b2b_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("pt2_valid", 32'(out_valid), 32'd1);
        chk("pt2_data", 32'(memory_stage_out), 32'd2);
        chk("pt2_rd", 32'(rd_addr_out), 32'd4);
        idle_in();
        step();
        chk("pt_drain_valid", 32'(out_valid), 32'd0);
        chk("pt_drain_busy", 32'(busy), 32'd0);

        // Store then load with address wrap
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'd5, 24'hABCDEF, 4'd0);
        step();
        chk("st_valid", 32'(out_valid), 32'd1);
        chk("st_data_is_alu", 32'(memory_stage_out), 32'd5);
        chk("st_mr_out", 32'(mem_read_enable_out), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 24'h400005, '0, 4'd7);
        step();
        idle_in();
        chk("ld_access_valid", 32'(out_valid), 32'd0);
        chk("ld_access_busy", 32'(busy), 32'd1);
        chk("ld_access_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("ld_access2_valid", 32'(out_valid), 32'd0);
        step();
        chk("ld_wrap_valid", 32'(out_valid), 32'd1);
        chk("ld_wrap_data", 32'(memory_stage_out), 32'hABCDEF);
        chk("ld_wrap_mr_out", 32'(mem_read_enable_out), 32'd1);
        chk("ld_wrap_rd", 32'(rd_addr_out), 32'd7);
        step();
        chk("ld_drain_valid", 32'(out_valid), 32'd0);

        // Latency and stall: store 0x000123 to 7, load with out_ready low
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'd7, 24'h000123, 4'd0);
        step();
        idle_in();
        step();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 24'd7, '0, 4'd9);
        #1;
        chk("stall_accept_ready", 32'(in_ready), 32'd1);
        step();
        idle_in();
        chk("stall_c1_in_ready", 32'(in_ready), 32'd0);
        chk("stall_c1_valid", 32'(out_valid), 32'd0);
        step();
        chk("stall_c2_in_ready", 32'(in_ready), 32'd0);
        chk("stall_c2_valid", 32'(out_valid), 32'd0);
        step();
        chk("stall_c3_in_ready", 32'(in_ready), 32'd0);
        chk("stall_c3_valid", 32'(out_valid), 32'd1);
        chk("stall_c3_data", 32'(memory_stage_out), 32'h000123);
        step();
        chk("stall_c4_valid", 32'(out_valid), 32'd1);
        chk("stall_c4_data", 32'(memory_stage_out), 32'h000123);
        chk("stall_c4_rd", 32'(rd_addr_out), 32'd9);
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        step();
        chk("stall_drain_valid", 32'(out_valid), 32'd0);

        // Flush mid-access
        drive(1'b1, 1'b1, 1'b1, 1'b0, 24'd5, '0, 4'd2);
        step();
        idle_in();
        flush = 1'b1;
        chk("fl_busy_before", 32'(busy), 32'd1);
        step();
        flush = 1'b0;
        chk("fl_busy_after", 32'(busy), 32'd0);
        chk("fl_valid_after", 32'(out_valid), 32'd0);
        step();
        chk("fl_valid_later1", 32'(out_valid), 32'd0);
        step();
        chk("fl_valid_later2", 32'(out_valid), 32'd0);
        load_and_wait(24'd7, 4'd6);
        chk("fl_next_valid", 32'(out_valid), 32'd1);
        chk("fl_next_data", 32'(memory_stage_out), 32'h000123);
        step();

        // Flush versus store at address 9
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'd9, 24'h111111, 4'd0);
        step();
        idle_in();
        step();
        flush = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'd9, 24'h999999, 4'd0);
        #1;
        chk("fs_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        idle_in();
        chk("fs_valid", 32'(out_valid), 32'd0);
        load_and_wait(24'd9, 4'd1);
        chk("fs_mem_unchanged", 32'(memory_stage_out), 32'h111111);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'd9, 24'h999999, 4'd0);
        step();
        chk("fs_store_valid", 32'(out_valid), 32'd1);
        load_and_wait(24'd9, 4'd1);
        chk("fs_mem_updated", 32'(memory_stage_out), 32'h999999);
        step();

        // Load and store together: write-first
        drive(1'b1, 1'b1, 1'b1, 1'b1, 24'd12, 24'h5A5A5A, 4'd5);
        step();
        idle_in();
        step();
        step();
        chk("wf_valid", 32'(out_valid), 32'd1);
        chk("wf_data", 32'(memory_stage_out), 32'h5A5A5A);

        // Reset has priority over flush
        rst   = 1'b1;
        flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        chk("rst_pri_valid", 32'(out_valid), 32'd0);
        chk("rst_pri_data", 32'(memory_stage_out), 32'd0);
        chk("rst_pri_mr", 32'(mem_read_enable_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
